fir_flow_ctrl: RTL and testbench

FIR_FLOW_CTRL -- requirements
Module: fir_flow_ctrl

---
 rtl/fir_flow_ctrl.sv | 144 ++++++++++++++
 tb/tb_fir_flow_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_flow_ctrl.sv
// Flow controller wrapping a fixed-latency FIR: upstream/downstream handshakes, drain on flush.
// Optional macro FIR_FLOW_CTRL_STATS_EN adds the stall_cycles counter output.
module fir_flow_ctrl #(
  parameter int DW         = 18,
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy,
  output logic                 fir_clk_ena,
  output logic                 fir_i_valid,
  output logic signed [DW-1:0] fir_i_in,
  input  logic                 fir_o_valid,
  input  logic signed [DW-1:0] fir_o_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data
`ifdef FIR_FLOW_CTRL_STATS_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int IW = $clog2(LATENCY + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic                r_flush_done;
  logic                w_done_next;
  logic                r_adv_d;
  logic [IW-1:0]       r_inflight;
  logic [IW-1:0]       w_inflight_next;
  logic [CW-1:0]       r_fifo_count;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic signed [DW-1:0] r_mem [FIFO_DEPTH];

  logic w_space;
  logic w_in_ready;
  logic w_accept;
  logic w_adv;
  logic w_push;
  logic w_pop;

  // One FIFO slot is held back for every advance whose result has not landed yet.
  assign w_space    = ({1'b0, r_fifo_count} + {{CW{1'b0}}, r_adv_d}) < (CW + 1)'(FIFO_DEPTH);
  assign w_in_ready = w_space && (r_state != ST_FLUSH);
  assign w_accept   = in_valid && w_in_ready && !reset;
  assign w_adv      = w_accept || ((r_state == ST_FLUSH) && w_space && !reset);
  assign w_push     = r_adv_d && fir_o_valid;
  assign w_pop      = (r_fifo_count != '0) && out_ready;

  assign w_inflight_next = r_inflight + IW'(w_accept) - IW'(w_push);

  assign in_ready    = w_in_ready;
  assign fir_clk_ena = w_adv;
  assign fir_i_valid = w_accept;
  assign fir_i_in    = w_accept ? in_data : '0;
  assign out_valid   = (r_fifo_count != '0);
  assign out_data    = r_mem[r_rd_ptr];
  assign flush_done  = r_flush_done;
  assign busy        = (r_state != ST_IDLE) || (r_inflight != '0) || (r_fifo_count != '0);

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flush) begin
          if ((r_inflight != '0) || w_accept) w_state_next = ST_FLUSH;
          else                                w_done_next  = 1'b1;
        end else if (w_accept) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Leave as the last sample is pushed; that cycle may still advance once with no valid.
        if (w_inflight_next == '0) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_flush_done <= 1'b0;
      r_adv_d      <= 1'b0;
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_flush_done <= w_done_next;
      r_adv_d      <= w_adv;
      r_inflight   <= w_inflight_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CW'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= fir_o_out;
  end

`ifdef FIR_FLOW_CTRL_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (in_valid && !w_in_ready && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fir_flow_ctrl.sv
// Self-checking bench for fir_flow_ctrl with a behavioural fixed-latency filter and an output scoreboard.
// Build with FIR_FLOW_CTRL_STATS_EN to also exercise stall_cycles.
module tb_fir_flow_ctrl;

  localparam int DW         = 18;
  localparam int LATENCY    = 21;
  localparam int FIFO_DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 flush;
  logic                 flush_done;
  logic                 busy;
  logic                 fir_clk_ena;
  logic                 fir_i_valid;
  logic signed [DW-1:0] fir_i_in;
  logic                 fir_o_valid;
  logic signed [DW-1:0] fir_o_out;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
`ifdef FIR_FLOW_CTRL_STATS_EN
  logic [31:0]          stall_cycles;
`endif

  fir_flow_ctrl #(.DW(DW), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .flush       (flush),
    .flush_done  (flush_done),
    .busy        (busy),
    .fir_clk_ena (fir_clk_ena),
    .fir_i_valid (fir_i_valid),
    .fir_i_in    (fir_i_in),
    .fir_o_valid (fir_o_valid),
    .fir_o_out   (fir_o_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef FIR_FLOW_CTRL_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural filter: pure delay line advancing only on fir_clk_ena.
  logic          pipe_v [LATENCY];
  logic [DW-1:0] pipe_d [LATENCY];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else if (fir_clk_ena) begin
      pipe_v[0] <= fir_i_valid;
      pipe_d[0] <= fir_i_in;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign fir_o_valid = pipe_v[LATENCY-1];
  assign fir_o_out   = pipe_d[LATENCY-1];

  int checks   = 0;
  int failures = 0;
  int acc_cnt, ena_cnt, ena_zero_cnt, out_cnt, fd_cnt, stall_cnt;
  logic signed [DW-1:0] exp_q [$];
  logic signed [DW-1:0] exp_v;
  logic [7:0] rdy_mask = 8'hFF;
  int         rdy_ph   = 0;
  bit         sent_done;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        acc_cnt++;
      end
      if (in_valid && !in_ready) stall_cnt++;
      if (fir_clk_ena) begin
        ena_cnt++;
        if (!fir_i_valid) ena_zero_cnt++;
      end
      if (flush_done) fd_cnt++;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0d required=none", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          $display("out data=%0d expected=%0d", out_data, exp_v);
          check("out_data", out_data, exp_v);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mask[rdy_ph[2:0]];
      rdy_ph++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    acc_cnt = 0; ena_cnt = 0; ena_zero_cnt = 0; out_cnt = 0; fd_cnt = 0; stall_cnt = 0;
  endtask

  task automatic send(input logic signed [DW-1:0] v);
    int t = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("send_accepted", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic flush_and_wait();
    int t = 0;
    int fd0 = fd_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    while (fd_cnt == fd0 && t < 3000) begin
      tick();
      t++;
    end
    check("flush_done_seen", fd_cnt - fd0, 1);
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (out_cnt < n && t < 1000) begin
      tick();
      t++;
    end
    tick();
  endtask

  typedef struct {
    int         n;
    int         start;
    logic [7:0] mask;
    int         exp_flush_adv;
    int         exp_stalls;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int   t;

    vecs[0] = '{30, 1,   8'hFF,        LATENCY, 0};
    vecs[1] = '{1,  5,   8'hFF,        LATENCY, 0};
    vecs[2] = '{12, 200, 8'b1011_0010, -1,      -1};
    vecs[3] = '{9,  -7,  8'b0001_0001, -1,      -1};

    // Reset behaviour, with in_valid deliberately high.
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 18'sd7;
    clear_counts();
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_fir_clk_ena", fir_clk_ena, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Flush while idle and empty.
    tick();
    clear_counts();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("idle_flush_done", flush_done, 1);
    check("idle_flush_busy", busy, 0);
    tick();
    @(negedge clk);
    check("idle_flush_done_once", flush_done, 0);
    repeat (3) tick();
    check("idle_flush_ena", ena_cnt, 0);
    check("idle_flush_fd_cnt", fd_cnt, 1);

    // Table-driven streams, each followed by a flush.
    for (int r = 0; r < 4; r++) begin
      clear_counts();
      rdy_mask = vecs[r].mask;
      for (int k = 0; k < vecs[r].n; k++) send(DW'(vecs[r].start + k));
      check("row_accepted", acc_cnt, vecs[r].n);
      if (vecs[r].exp_stalls >= 0) check("row_stalls", stall_cnt, vecs[r].exp_stalls);
      flush_and_wait();
      drain(vecs[r].n);
      $display("row %0d: n=%0d outputs=%0d flush_adv=%0d", r, vecs[r].n, out_cnt, ena_zero_cnt);
      check("row_outputs", out_cnt, vecs[r].n);
      check("row_sb_empty", exp_q.size(), 0);
      check("row_data_adv", ena_cnt - ena_zero_cnt, vecs[r].n);
      check("row_fd_cnt", fd_cnt, 1);
      check("row_busy", busy, 0);
      if (vecs[r].exp_flush_adv >= 0) check("row_flush_adv", ena_zero_cnt, vecs[r].exp_flush_adv);
    end

    // Output stalled: FIFO fills, pipeline freezes, then recovers in order.
    clear_counts();
    rdy_mask  = 8'h00;
    sent_done = 1'b0;
    fork
      begin
        for (int k = 1; k <= 30; k++) send(DW'(k));
        sent_done = 1'b1;
      end
    join_none
    repeat (40) tick();
    @(negedge clk);
    check("full_out_valid", out_valid, 1);
    check("full_fir_clk_ena", fir_clk_ena, 0);
    check("full_in_ready", in_ready, 0);
    check("full_accepted", acc_cnt, LATENCY + FIFO_DEPTH - 1);
    check("full_no_output", out_cnt, 0);
    tick();
    rdy_mask = 8'hFF;
    t = 0;
    while (!sent_done && t < 2000) begin
      tick();
      t++;
    end
    check("full_sent_done", sent_done, 1);
    flush_and_wait();
    drain(30);
    check("full_outputs", out_cnt, 30);
    check("full_sb_empty", exp_q.size(), 0);
    check("full_busy", busy, 0);

    // Reset in the middle of a flush with two results waiting.
    clear_counts();
    rdy_mask = 8'h00;
    repeat (2) tick();
    for (int k = 1; k <= 6; k++) send(DW'(50 + k));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("midflush_out_valid", out_valid, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midflush_rst_out_valid", out_valid, 0);
    check("midflush_rst_busy", busy, 0);
    check("midflush_rst_in_ready", in_ready, 1);
    check("midflush_rst_flush_done", flush_done, 0);
    rdy_mask = 8'hFF;
    repeat (30) tick();
    check("midflush_no_output", out_cnt, 0);
    send(18'sd77);
    flush_and_wait();
    drain(1);
    check("midflush_recover_outputs", out_cnt, 1);
    check("midflush_recover_sb", exp_q.size(), 0);

`ifdef FIR_FLOW_CTRL_STATS_EN
    // Held input against a full FIFO counts stalled cycles.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("stats_reset", stall_cycles, 0);
    tick();
    rdy_mask = 8'h00;
    repeat (2) tick();
    in_valid = 1'b1;
    in_data  = 18'sd9;
    t = 0;
    @(negedge clk);
    while (in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stats_full", in_ready, 0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stats_stall_cycles", stall_cycles, 10);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    rdy_mask = 8'hFF;
`endif

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
